// File: rtl/imm_pkg.sv
// Shared types for the immediate generator: format selects, width constants
// and the extended-entry record carried through the output and skid stages.
package imm_pkg;

    localparam int XLEN_32 = 32;
    localparam int XLEN_64 = 64;

    typedef enum logic [2:0] {
        IMM_I    = 3'b000,
        IMM_S    = 3'b001,
        IMM_B    = 3'b010,
        IMM_J    = 3'b011,
        IMM_U    = 3'b100,
        IMM_Z    = 3'b101,
        IMM_SH   = 3'b110,
        IMM_RSVD = 3'b111
    } imm_src_e;

    // Sized for the widest datapath; narrower builds keep the upper bits zero.
    typedef struct packed {
        logic [XLEN_64-1:0] imm;
        logic [XLEN_64-1:0] target;
        logic               fmt_err;
    } imm_entry_t;

endpackage

// File: rtl/imm_extend_core.sv
// Combinational format decode, sign/zero extension and PC+imm target adder.
// The instruction arrives without its opcode bits, so it is indexed as [31:7].
module imm_extend_core
    import imm_pkg::*;
#(
    parameter int XLEN      = 32,
    parameter bit TARGET_EN = 1'b1
) (
    input  logic [24:0]     instr,
    input  imm_src_e        imm_src,
    input  logic [XLEN-1:0] pc,
    output imm_entry_t      entry
);

    logic [31:7]        ir;
    logic signed [11:0] i_imm;
    logic signed [11:0] s_imm;
    logic signed [12:0] b_imm;
    logic signed [20:0] j_imm;
    logic signed [31:0] u_imm;
    logic [XLEN-1:0]    imm;
    logic [XLEN-1:0]    sum;
    logic               err;

    assign ir    = instr;
    assign i_imm = ir[31:20];
    assign s_imm = {ir[31:25], ir[11:7]};
    assign b_imm = {ir[31], ir[7], ir[30:25], ir[11:8], 1'b0};
    assign j_imm = {ir[31], ir[19:12], ir[20], ir[30:21], 1'b0};
    assign u_imm = {ir[31:12], 12'b0};

    always_comb begin
        // NOTE: every output of a combinational block gets a default first, so no path infers a latch.
        imm = '0;
        err = 1'b0;
        case (imm_src)
            IMM_I:   imm = XLEN'(i_imm);
            IMM_S:   imm = XLEN'(s_imm);
            IMM_B:   imm = XLEN'(b_imm);
            IMM_J:   imm = XLEN'(j_imm);
            IMM_U:   imm = XLEN'(u_imm);
            IMM_Z:   imm = XLEN'(ir[19:15]);
            IMM_SH:  imm = (XLEN == XLEN_64) ? XLEN'(ir[25:20]) : XLEN'(ir[24:20]);
            default: err = 1'b1;
        endcase
    end

    // Sum is formed at XLEN so the carry out of the top bit is dropped.
    assign sum = pc + imm;

    assign entry.imm     = XLEN_64'(imm);
    assign entry.target  = TARGET_EN ? XLEN_64'(sum) : '0;
    assign entry.fmt_err = err;

endmodule

// File: rtl/imm_gen_pipe.sv
// Registered immediate generator between decode and execute: one output stage
// plus a one-entry skid so in_ready depends only on registered state.
module imm_gen_pipe
    import imm_pkg::*;
#(
    parameter int XLEN      = 32,
    parameter bit TARGET_EN = 1'b1
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [24:0]     in_instr,
    input  imm_src_e        in_imm_src,
    input  logic [XLEN-1:0] in_pc,
    input  logic            flush,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_imm,
    output logic [XLEN-1:0] out_target,
    output logic            out_fmt_err
);

    imm_entry_t core_entry;
    imm_entry_t out_q;
    imm_entry_t skid_q;
    logic       out_valid_q;
    logic       skid_valid_q;
    logic       in_fire;
    logic       out_free;

    imm_extend_core #(
        .XLEN      (XLEN),
        .TARGET_EN (TARGET_EN)
    ) u_core (
        .instr   (in_instr),
        .imm_src (in_imm_src),
        .pc      (in_pc),
        .entry   (core_entry)
    );

    assign in_ready = !skid_valid_q && !reset;
    assign in_fire  = in_valid && in_ready && !flush;
    assign out_free = !out_valid_q || out_ready;

    always_ff @(posedge clk) begin
        // NOTE: sequential state is written with non-blocking assignments only.
        if (reset) begin
            out_valid_q  <= 1'b0;
            skid_valid_q <= 1'b0;
            out_q        <= '0;
        end else if (flush) begin
            out_valid_q  <= 1'b0;
            skid_valid_q <= 1'b0;
        end else if (out_free) begin
            if (skid_valid_q) begin
                out_q        <= skid_q;
                out_valid_q  <= 1'b1;
                skid_valid_q <= 1'b0;
            end else begin
                out_valid_q <= in_fire;
                if (in_fire) begin
                    out_q <= core_entry;
                end
            end
        end else if (in_fire) begin
            skid_valid_q <= 1'b1;
        end
    end

    // NOTE: the skid payload has no reset; skid_valid_q alone says whether it is meaningful.
    always_ff @(posedge clk) begin
        if (in_fire && !out_free) begin
            skid_q <= core_entry;
        end
    end

    assign out_valid   = out_valid_q;
    assign out_imm     = out_q.imm[XLEN-1:0];
    assign out_target  = out_q.target[XLEN-1:0];
    assign out_fmt_err = out_q.fmt_err;

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Scoreboard bench: 32- and 64-bit instances share stimulus; accepted entries
// queue their hand-computed results and a monitor compares on every out fire.
module tb_imm_gen_pipe;
    import imm_pkg::*;

    typedef struct {
        imm_src_e    src;
        logic [31:0] instr;
        logic [63:0] pc;
        logic [31:0] imm32;
        logic [31:0] tgt32;
        logic [63:0] imm64;
        logic [63:0] tgt64;
        logic        err;
    } vec_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        flush;
    logic        out_ready;
    logic [24:0] in_instr;
    imm_src_e    in_imm_src;
    logic [63:0] pc;

    logic        in_ready32, out_valid32, out_fmt_err32;
    logic [31:0] out_imm32, out_target32;
    logic        in_ready64, out_valid64, out_fmt_err64;
    logic [63:0] out_imm64, out_target64;

    vec_t vecs[$];
    vec_t sb[$];
    vec_t cur;
    int   n_checks = 0;
    int   n_fail   = 0;

    always #5 clk = ~clk;

    imm_gen_pipe #(.XLEN(32), .TARGET_EN(1'b1)) dut32 (
        .clk         (clk),
        .reset       (reset),
        .in_valid    (in_valid),
        .in_ready    (in_ready32),
        .in_instr    (in_instr),
        .in_imm_src  (in_imm_src),
        .in_pc       (pc[31:0]),
        .flush       (flush),
        .out_valid   (out_valid32),
        .out_ready   (out_ready),
        .out_imm     (out_imm32),
        .out_target  (out_target32),
        .out_fmt_err (out_fmt_err32)
    );

    imm_gen_pipe #(.XLEN(64), .TARGET_EN(1'b1)) dut64 (
        .clk         (clk),
        .reset       (reset),
        .in_valid    (in_valid),
        .in_ready    (in_ready64),
        .in_instr    (in_instr),
        .in_imm_src  (in_imm_src),
        .in_pc       (pc),
        .flush       (flush),
        .out_valid   (out_valid64),
        .out_ready   (out_ready),
        .out_imm     (out_imm64),
        .out_target  (out_target64),
        .out_fmt_err (out_fmt_err64)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic vec_t mk(input imm_src_e s, input logic [31:0] ins, input logic [63:0] p,
                                input logic [31:0] i32, input logic [31:0] t32,
                                input logic [63:0] i64, input logic [63:0] t64, input logic e);
        vec_t v;
        v.src = s; v.instr = ins; v.pc = p;
        v.imm32 = i32; v.tgt32 = t32; v.imm64 = i64; v.tgt64 = t64; v.err = e;
        return v;
    endfunction

    // Input side: whatever is offered while in_ready is high (and no flush/reset) is accepted at the next edge.
    always @(negedge clk) begin
        if (reset || flush) begin
            sb.delete();
        end else if (in_valid && in_ready32) begin
            check("in_ready64", {63'b0, in_ready64}, 64'd1);
            sb.push_back(cur);
        end
    end

    // Output side: every out fire must match the oldest outstanding entry.
    always @(negedge clk) begin
        vec_t e;
        if (!reset && !flush && out_valid32 && out_ready) begin
            check("out_valid64", {63'b0, out_valid64}, 64'd1);
            if (sb.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_output: got imm %h while no entry was expected", out_imm32);
            end else begin
                e = sb.pop_front();
                check("imm32",    {32'b0, out_imm32},    {32'b0, e.imm32});
                check("target32", {32'b0, out_target32}, {32'b0, e.tgt32});
                check("fmt_err32", {63'b0, out_fmt_err32}, {63'b0, e.err});
                check("imm64",    out_imm64,    e.imm64);
                check("target64", out_target64, e.tgt64);
                check("fmt_err64", {63'b0, out_fmt_err64}, {63'b0, e.err});
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input vec_t v);
        in_valid   = 1'b1;
        in_imm_src = v.src;
        in_instr   = v.instr[31:7];
        pc         = v.pc;
        cur        = v;
    endtask

    task automatic idle();
        in_valid = 1'b0;
    endtask

    task automatic send(input int i);
        bit acc = 1'b0;
        drive(vecs[i]);
        for (int n = 0; n < 50 && !acc; n++) begin
            @(negedge clk);
            acc = in_ready32 && !flush && !reset;
            tick();
        end
        if (!acc) begin
            n_checks++;
            n_fail++;
            $display("FAIL send_timeout: vector %0d never accepted", i);
        end
    endtask

    task automatic drain();
        for (int n = 0; n < 20 && sb.size() != 0; n++) tick();
        check("drain_empty", 64'(sb.size()), 64'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int bp[4] = '{9, 4, 6, 2};
        int idx;

        vecs.push_back(mk(IMM_B,    32'hFE000EE3, 64'h100,      32'hFFFFFFFC, 32'h000000FC, 64'hFFFFFFFFFFFFFFFC, 64'hFC,               1'b0));
        vecs.push_back(mk(IMM_I,    32'hFFF00093, 64'h1000,     32'hFFFFFFFF, 32'h00000FFF, 64'hFFFFFFFFFFFFFFFF, 64'hFFF,              1'b0));
        vecs.push_back(mk(IMM_U,    32'h800000B7, 64'h10,       32'h80000000, 32'h80000010, 64'hFFFFFFFF80000000, 64'hFFFFFFFF80000010, 1'b0));
        vecs.push_back(mk(IMM_J,    32'hFF9FF06F, 64'h8,        32'hFFFFFFF8, 32'h00000000, 64'hFFFFFFFFFFFFFFF8, 64'h0,                1'b0));
        vecs.push_back(mk(IMM_Z,    32'h000F8073, 64'h200,      32'h0000001F, 32'h0000021F, 64'h1F,               64'h21F,              1'b0));
        vecs.push_back(mk(IMM_SH,   32'h03F01013, 64'h0,        32'h0000001F, 32'h0000001F, 64'h3F,               64'h3F,               1'b0));
        vecs.push_back(mk(IMM_S,    32'hFE112E23, 64'h104,      32'hFFFFFFFC, 32'h00000100, 64'hFFFFFFFFFFFFFFFC, 64'h100,              1'b0));
        vecs.push_back(mk(IMM_RSVD, 32'hFFFFFFFF, 64'h40,       32'h00000000, 32'h00000040, 64'h0,                64'h40,               1'b1));
        vecs.push_back(mk(IMM_I,    32'h00100013, 64'hFFFFFFFF, 32'h00000001, 32'h00000000, 64'h1,                64'h100000000,        1'b0));
        vecs.push_back(mk(IMM_I,    32'h7FF00013, 64'h0,        32'h000007FF, 32'h000007FF, 64'h7FF,              64'h7FF,              1'b0));

        reset = 1'b1; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1;
        in_instr = '0; in_imm_src = IMM_I; pc = '0; cur = vecs[0];
        repeat (3) tick();
        @(negedge clk);
        check("rst_in_ready",  {63'b0, in_ready32},  64'd0);
        check("rst_out_valid", {63'b0, out_valid32}, 64'd0);
        check("rst_imm32",     {32'b0, out_imm32},   64'd0);
        check("rst_target64",  out_target64,         64'd0);
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        check("in_ready_after_reset", {63'b0, in_ready32}, 64'd1);
        tick();

        // Streaming with out_ready high; first entry must appear one cycle after acceptance.
        send(0);
        idle();
        @(negedge clk);
        check("latency_1cyc", {63'b0, out_valid32}, 64'd1);
        tick();
        for (int i = 1; i < 10; i++) send(i);
        idle();
        drain();

        // Backpressure: offer A..D every cycle, out_ready low for the first three cycles.
        idx = 0;
        for (int cyc = 0; cyc < 8; cyc++) begin
            out_ready = (cyc >= 3);
            if (idx < 4) drive(vecs[bp[idx]]);
            else idle();
            @(negedge clk);
            if (cyc == 2) check("bp_in_ready_low", {63'b0, in_ready32}, 64'd0);
            if (cyc >= 3 && cyc <= 6) check("bp_no_gap", {63'b0, out_valid32}, 64'd1);
            if (idx < 4 && in_ready32) idx++;
            tick();
        end
        check("bp_accepts", 64'(idx), 64'd4);
        drain();

        // Flush with both stages full while another entry is offered.
        out_ready = 1'b0;
        send(1);
        send(3);
        @(negedge clk);
        check("full_in_ready", {63'b0, in_ready32}, 64'd0);
        @(posedge clk); #1;
        flush = 1'b1;
        drive(vecs[7]);
        tick();
        flush = 1'b0;
        idle();
        @(negedge clk);
        check("flush_out_valid", {63'b0, out_valid32}, 64'd0);
        check("flush_in_ready",  {63'b0, in_ready32},  64'd1);
        tick();

        // Flush while in_ready is high: the offered entry must not be captured.
        send(0);
        flush = 1'b1;
        drive(vecs[5]);
        @(negedge clk);
        check("flush_cycle_in_ready", {63'b0, in_ready32}, 64'd1);
        tick();
        flush = 1'b0;
        idle();
        @(negedge clk);
        check("flush_drop_offered", {63'b0, out_valid32}, 64'd0);
        tick();
        out_ready = 1'b1;
        send(8);
        idle();
        drain();

        // Reset asserted with both stages full.
        out_ready = 1'b0;
        send(2);
        send(4);
        idle();
        reset = 1'b1;
        @(negedge clk);
        check("reset_in_ready_low", {63'b0, in_ready32}, 64'd0);
        tick();
        tick();
        @(negedge clk);
        check("midrst_out_valid", {63'b0, out_valid32},   64'd0);
        check("midrst_imm32",     {32'b0, out_imm32},     64'd0);
        check("midrst_target32",  {32'b0, out_target32},  64'd0);
        check("midrst_fmt_err",   {63'b0, out_fmt_err32}, 64'd0);
        check("midrst_imm64",     out_imm64,              64'd0);
        check("midrst_target64",  out_target64,           64'd0);
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        check("post_rst_in_ready",  {63'b0, in_ready32},  64'd1);
        check("post_rst_out_valid", {63'b0, out_valid32}, 64'd0);
        tick();
        out_ready = 1'b1;
        send(6);
        idle();
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
